bram_fetch_arbiter: RTL

- Shares the single Port-B read path of the weight/bias/input BRAM between NUM_REQ fetch requesters, such as the weight, bias and input tile fetchers.
- Each requester asks for a burst, given as a base address and a beat count.
- The arbiter grants whole bursts round-robin and drives the BRAM enable and address, one beat per cycle.
- It tags returning read data with the owning requester and pulses a per-requester done when the last beat of a burst has returned.

---
 rtl/bram_fetch_arbiter_pkg.sv | 21 ++
 rtl/bram_fetch_arbiter_pick.sv | 31 +++
 rtl/bram_fetch_arbiter.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/bram_fetch_arbiter_pkg.sv
// Shared types and constants for the BRAM Port-B fetch arbiter.
// Default widths match the weight/bias/input buffer.
package bram_fetch_arbiter_pkg;

    localparam int DEF_NUM_REQ    = 3;
    localparam int DEF_ADDR_WIDTH = 11;
    localparam int DEF_DATA_WIDTH = 256;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_ID_WIDTH = id_width(DEF_NUM_REQ);

endpackage

// File: rtl/bram_fetch_arbiter_pick.sv
// Round-robin winner select: first set request at or above rr_ptr,
// wrapping at NUM_REQ.
module rr_priority_pick #(
    parameter int NUM_REQ = 3,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic [ID_W-1:0]    winner_idx,
    output logic               any_req
);

    function automatic int wrap_idx(input logic [ID_W-1:0] ptr, input int i);
        return (int'(ptr) + i) % NUM_REQ;
    endfunction

    always_comb begin
        winner     = '0;
        winner_idx = '0;
        any_req    = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!any_req && req[wrap_idx(rr_ptr, i)]) begin
                any_req                     = 1'b1;
                winner[wrap_idx(rr_ptr, i)] = 1'b1;
                winner_idx                  = ID_W'(wrap_idx(rr_ptr, i));
            end
        end
    end

endmodule

// File: rtl/bram_fetch_arbiter.sv
// Round-robin burst arbiter sharing the BRAM Port-B read path between
// NUM_REQ fetchers; tags returning beats and flags burst completion.
module bram_fetch_arbiter
    import bram_fetch_arbiter_pkg::*;
#(
    parameter  int NUM_REQ    = DEF_NUM_REQ,
    parameter  int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter  int LEN_WIDTH  = 8,
    parameter  int RD_LATENCY = 2,
    localparam int ID_W       = id_width(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_base_addr,
    input  logic [NUM_REQ*LEN_WIDTH-1:0]  req_len,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          bram_en,
    output logic [ADDR_WIDTH-1:0]         bram_addr,
    input  logic [DATA_WIDTH-1:0]         bram_dout,
    output logic [DATA_WIDTH-1:0]         rd_data,
    output logic                          rd_valid,
    output logic [ID_W-1:0]               rd_id,
    output logic [NUM_REQ-1:0]            burst_done,
    output logic                          busy
);

    state_t                state;
    logic [ID_W-1:0]       rr_ptr;
    logic [ID_W-1:0]       owner;
    logic [LEN_WIDTH-1:0]  remaining;
    logic                  bram_last;

    logic [NUM_REQ-1:0]    win_onehot;
    logic [ID_W-1:0]       win_idx;
    logic                  any_req;
    logic [ADDR_WIDTH-1:0] win_base;
    logic [LEN_WIDTH-1:0]  win_len;
    logic                  zero_start;
    logic [ID_W-1:0]       rr_next;

    logic [RD_LATENCY-1:0] en_pipe;
    logic [RD_LATENCY-1:0] last_pipe;
    logic [ID_W-1:0]       id_pipe [RD_LATENCY];

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req        (req),
        .rr_ptr     (rr_ptr),
        .winner     (win_onehot),
        .winner_idx (win_idx),
        .any_req    (any_req)
    );

    assign win_base = req_base_addr[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
    assign win_len  = req_len[win_idx*LEN_WIDTH +: LEN_WIDTH];
    assign rr_next  = (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;

    // A zero-length burst injects its completion token straight into the
    // pipeline so burst_done lands RD_LATENCY cycles after arbitration.
    assign zero_start = (state == IDLE) && any_req && (win_len == '0);

    assign busy     = (state != IDLE);
    assign rd_data  = bram_dout;
    assign rd_valid = en_pipe[RD_LATENCY-1];
    assign rd_id    = id_pipe[RD_LATENCY-1];

    always_comb begin
        burst_done = '0;
        if (last_pipe[RD_LATENCY-1]) begin
            burst_done[id_pipe[RD_LATENCY-1]] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            remaining <= '0;
            grant     <= '0;
            bram_en   <= 1'b0;
            bram_last <= 1'b0;
            bram_addr <= '0;
            en_pipe   <= '0;
            last_pipe <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                id_pipe[i] <= '0;
            end
        end else begin
            for (int i = RD_LATENCY - 1; i > 0; i--) begin
                en_pipe[i]   <= en_pipe[i-1];
                last_pipe[i] <= last_pipe[i-1];
                id_pipe[i]   <= id_pipe[i-1];
            end
            en_pipe[0]   <= bram_en;
            last_pipe[0] <= bram_last | zero_start;
            id_pipe[0]   <= (state == IDLE) ? win_idx : owner;

            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        grant  <= win_onehot;
                        owner  <= win_idx;
                        rr_ptr <= rr_next;
                        if (win_len != '0) begin
                            bram_en   <= 1'b1;
                            bram_addr <= win_base;
                            bram_last <= (win_len == LEN_WIDTH'(1));
                            remaining <= win_len - 1'b1;
                            state     <= ISSUE;
                        end else begin
                            state <= DRAIN;
                        end
                    end
                end
                ISSUE: begin
                    if (remaining == '0) begin
                        bram_en   <= 1'b0;
                        bram_last <= 1'b0;
                        state     <= DRAIN;
                    end else begin
                        bram_addr <= bram_addr + 1'b1;
                        bram_last <= (remaining == LEN_WIDTH'(1));
                        remaining <= remaining - 1'b1;
                    end
                end
                DRAIN: begin
                    if (last_pipe[RD_LATENCY-1]) begin
                        grant <= '0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
